serial_subtractor: RTL
======================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL use a single clock; reset SHALL be asynchronous and active-high.
REQ-002 Parameter: WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst  input  1  asynchronous active-high reset.
REQ-005 Port: start  input  1  request to begin a subtraction; sampled on rising clk edges.
REQ-006 Port: a  input  WIDTH  minuend; sampled only when start is accepted.
REQ-007 Port: b  input  WIDTH  subtrahend; sampled only when start is accepted.
REQ-008 Port: bin  input  1  borrow-in; sampled only when start is accepted.
REQ-009 Port: busy  output  1  high while an operation is in progress (state RUN).
REQ-010 Port: done  output  1  single-cycle pulse marking a new valid result.
REQ-011 Port: diff  output  WIDTH  result a - b - bin, modulo 2^WIDTH.
REQ-012 Port: bout  output  1  borrow-out of the MSB; high when a < b + bin (unsigned).
REQ-013 Port: zero  output  1  high when diff == 0.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-015 IDLE -> RUN on any edge where start=1; a, b and bin are captured on that edge, and the bit counter and internal borrow are initialised on that edge (borrow = bin).
REQ-016 In RUN the block SHALL process one bit per clock, LSB first: d = a_i ^ b_i ^ br; br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
REQ-017 RUN SHALL last exactly WIDTH clock edges; on the WIDTH-th edge the state SHALL move to DONE and diff, bout and zero SHALL be updated together.
REQ-018 done SHALL be 1 only while in DONE, for exactly one cycle. With the start edge as E0, done SHALL be high in the cycle following edge E(WIDTH).
REQ-019 DONE -> RUN on an edge where start=1 (back-to-back, same capture rules as REQ-015); DONE -> IDLE otherwise.
REQ-020 start SHALL be ignored while in RUN: no recapture, no restart, no change in latency.
REQ-021 diff, bout and zero SHALL hold their last values from completion until the next completion; they SHALL NOT change during RUN.
REQ-022 busy SHALL be 1 exactly while in RUN.
REQ-023 zero SHALL reflect diff only; bout SHALL NOT affect zero.
REQ-024 Changes on a, b or bin outside an accepting edge SHALL have no effect on the operation in flight.

Reset
REQ-025 Reset assertion SHALL immediately force: state IDLE, busy=0, done=0, diff=0, bout=0, zero=0, internal borrow=0, bit counter=0, operand registers=0.
REQ-026 Reset during RUN or DONE SHALL abort the operation; no done pulse SHALL be produced for it.
REQ-027 start SHALL NOT be accepted while rst=1.
REQ-028 After reset deasserts, the first edge with start=1 SHALL be accepted normally.

Verification (WIDTH=8)
REQ-029 a=0x05, b=0x03, bin=0 -> diff=0x02, bout=0, zero=0; done high in the cycle after edge E8; busy high for 8 cycles.
REQ-030 a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1, zero=0.
REQ-031 a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1. Then a=0x7A, b=0x7A, bin=0 -> diff=0x00, zero=1, bout=0.
REQ-032 start with a=0x10, b=0x01, then at E3 pulse start with a=0xFF, b=0x00 -> second request ignored; result diff=0x0F, done still after E8.
REQ-033 Hold start=1 through DONE with new a=0x20, b=0x10 -> second operation accepted on the DONE edge; diff=0x10 with its done pulse 9 edges later; each done pulse is one cycle wide.
REQ-034 Assert rst during the 4th RUN cycle -> all outputs 0 and busy=0 immediately, no done pulse; the next start after reset completes normally.

Source files
------------

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial subtractor computing a - b - bin, LSB first
//
// Purpose: accepts a subtraction request, then resolves one result bit per clock
// for WIDTH clocks, and publishes diff/bout/zero together with a one-cycle done.
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst    in   1      asynchronous active-high reset
//   start  in   1      request; accepted in IDLE or DONE, ignored in RUN
//   a      in   WIDTH  minuend, captured on the accepting edge
//   b      in   WIDTH  subtrahend, captured on the accepting edge
//   bin    in   1      borrow-in, captured on the accepting edge
//   busy   out  1      high while in RUN
//   done   out  1      high for the single DONE cycle
//   diff   out  WIDTH  a - b - bin modulo 2^WIDTH, held until next completion
//   bout   out  1      borrow-out of the MSB
//   zero   out  1      diff == 0
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             zero_q, zero_d;

  // Operands shift right so the bit under work is always at position 0.
  logic             bit_w;
  logic             br_nxt_w;
  logic [WIDTH-1:0] acc_nxt_w;

  assign bit_w     = a_q[0] ^ b_q[0] ^ br_q;
  assign br_nxt_w  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  // Result bits enter at the MSB; after WIDTH shifts the LSB has reached bit 0.
  assign acc_nxt_w = {bit_w, acc_q[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      br_q   <= 1'b0;
      acc_q  <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      a_q    <= a_d;
      b_q    <= b_d;
      br_q   <= br_d;
      acc_q  <= acc_d;
      diff_q <= diff_d;
      bout_q <= bout_d;
      zero_q <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    acc_d   = acc_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    zero_d  = zero_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          cnt_d   = '0;
          acc_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = br_nxt_w;
        acc_d = acc_nxt_w;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // Final bit: publish all three results on the same edge.
          state_d = DONE;
          cnt_d   = '0;
          diff_d  = acc_nxt_w;
          bout_d  = br_nxt_w;
          zero_d  = (acc_nxt_w == '0);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;
  assign zero = zero_q;

endmodule
